// File: rtl/imfilter_pkg.sv
// Shared types and default constants for the UART image-filter frame sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imfilter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RECV = 3'd1,
        ST_PROC = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } ctrl_state_t;

    localparam int unsigned DEF_D_BITS      = 8;
    localparam int unsigned DEF_N           = 3;
    localparam int unsigned DEF_TIMEOUT_CYC = 100000;

endpackage

// File: rtl/imfilter_frame_ctrl_if.sv
// Groups the rx / operator / tx / status signals of the frame sequencer.
// Latency: n/a (wires only).
// Backpressure: operator req/ack handshake; tx paced by one tx_done per byte.
interface imfilter_frame_ctrl_if
    import imfilter_pkg::*;
#(
    parameter int unsigned D_BITS = DEF_D_BITS
);
    logic [D_BITS-1:0] i_rx_data;
    logic              i_rx_done;
    logic              o_op_req;
    logic [D_BITS-1:0] o_op_data;
    logic              i_op_ack;
    logic [D_BITS-1:0] i_op_result;
    logic [D_BITS-1:0] o_tx_data;
    logic              o_tx_enable;
    logic              i_tx_done;
    logic              o_busy;
    logic              o_frame_done;
    logic              o_err_timeout;
    logic              o_overrun;

    modport slave (
        input  i_rx_data, i_rx_done, i_op_ack, i_op_result, i_tx_done,
        output o_op_req, o_op_data, o_tx_data, o_tx_enable,
               o_busy, o_frame_done, o_err_timeout, o_overrun
    );

    modport master (
        output i_rx_data, i_rx_done, i_op_ack, i_op_result, i_tx_done,
        input  o_op_req, o_op_data, o_tx_data, o_tx_enable,
               o_busy, o_frame_done, o_err_timeout, o_overrun
    );
endinterface

// File: rtl/imfilter_frame_buf.sv
// N x D_BITS pixel register file, one write port, one asynchronous read port, no reset.
// Latency: write lands on the next clock edge; read is combinational.
// Backpressure: none; out-of-range read addresses return zero.
module imfilter_frame_buf #(
    parameter int unsigned D_BITS = 8,
    parameter int unsigned N      = 3,
    parameter int unsigned AW     = 2
)(
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [D_BITS-1:0] wdata_i,
    output logic [D_BITS-1:0] rdata_o
);
    logic [D_BITS-1:0] mem_q [N];

    // Pixel storage; contents survive reset on purpose.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = (addr_i < AW'(N)) ? mem_q[addr_i] : '0;
endmodule

// File: rtl/imfilter_frame_ctrl.sv
// Frame sequencer: collect N rx bytes, run each through the operator in place, stream results to tx.
// Latency: last rx -> op_req 1 cycle; final ack -> first tx_enable 2 cycles; tx_done -> next tx_enable 1 cycle.
// Backpressure: operator via req/ack, tx one outstanding byte; rx cannot be stalled (late bytes flag overrun).
// Optional: define IMFILTER_CHECKSUM_EN to append a mod-2^D_BITS sum of the results after the N-th byte.
module imfilter_frame_ctrl
    import imfilter_pkg::*;
#(
    parameter int unsigned D_BITS      = DEF_D_BITS,
    parameter int unsigned N           = DEF_N,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
)(
    input  logic i_clk,
    input  logic i_rst_n,
    imfilter_frame_ctrl_if.slave bus
);
    localparam int unsigned IW = $clog2(N + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
    localparam logic [IW-1:0] IDX_END  = IW'(N);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYC);

    ctrl_state_t       state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              gap_q, gap_d;
    logic [D_BITS-1:0] tx_data_q, tx_data_d;
    logic              tx_en_q, tx_en_d;
    logic              err_q, err_d;
    logic              ovr_q, ovr_d;
`ifdef IMFILTER_CHECKSUM_EN
    logic [D_BITS-1:0] sum_q, sum_d;
    logic              chk_q, chk_d;
`endif

    logic              buf_we;
    logic [D_BITS-1:0] buf_wdata;
    logic [D_BITS-1:0] buf_rdata;
    logic              op_req;
    logic              op_take;

    // Both ports address the buffer by idx: IDLE/RECV write position, PROC operand, SEND next byte.
    imfilter_frame_buf #(.D_BITS(D_BITS), .N(N), .AW(IW)) u_buf (
        .clk_i   (i_clk),
        .we_i    (buf_we),
        .addr_i  (idx_q),
        .wdata_i (buf_wdata),
        .rdata_o (buf_rdata)
    );

    assign op_req  = (state_q == ST_PROC) && !gap_q;
    assign op_take = bus.i_op_ack && op_req;

    // Next-state, counters and buffer write control.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tmo_d     = tmo_q;
        gap_d     = 1'b0;
        tx_data_d = tx_data_q;
        tx_en_d   = 1'b0;
        err_d     = 1'b0;
        ovr_d     = ovr_q;
        buf_we    = 1'b0;
        buf_wdata = bus.i_rx_data;
`ifdef IMFILTER_CHECKSUM_EN
        sum_d     = sum_q;
        chk_d     = chk_q;
`endif
        case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (bus.i_rx_done) begin
                    buf_we = 1'b1;
                    ovr_d  = 1'b0;
                    if (N == 1) begin
                        idx_d   = '0;
                        state_d = ST_PROC;
                    end else begin
                        idx_d   = IW'(1);
                        state_d = ST_RECV;
                    end
                end
            end
            ST_RECV: begin
                if (bus.i_rx_done) begin
                    // A byte in the expiry cycle still counts: the byte wins over the abort.
                    buf_we = 1'b1;
                    tmo_d  = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = ST_PROC;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    tmo_d = (tmo_q == TMO_MAX) ? TMO_MAX : tmo_q + TW'(1);
                    if (tmo_d == TMO_MAX) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        tmo_d   = '0;
                    end
                end
            end
            ST_PROC: begin
                if (bus.i_rx_done) ovr_d = 1'b1;
                if (op_take) begin
                    buf_we    = 1'b1;
                    buf_wdata = bus.i_op_result;
                    gap_d     = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = ST_SEND;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            ST_SEND: begin
                if (bus.i_rx_done) ovr_d = 1'b1;
                if (idx_q == '0) begin
                    // idx is zero only on the first SEND cycle: launch byte 0.
                    tx_data_d = buf_rdata;
                    tx_en_d   = 1'b1;
                    idx_d     = IW'(1);
`ifdef IMFILTER_CHECKSUM_EN
                    sum_d     = buf_rdata;
                    chk_d     = 1'b0;
`endif
                end else if (bus.i_tx_done) begin
                    if (idx_q < IDX_END) begin
                        tx_data_d = buf_rdata;
                        tx_en_d   = 1'b1;
                        idx_d     = idx_q + IW'(1);
`ifdef IMFILTER_CHECKSUM_EN
                        sum_d     = sum_q + buf_rdata;
`endif
                    end else begin
`ifdef IMFILTER_CHECKSUM_EN
                        if (!chk_q) begin
                            tx_data_d = sum_q;
                            tx_en_d   = 1'b1;
                            chk_d     = 1'b1;
                        end else begin
                            idx_d   = '0;
                            state_d = ST_DONE;
                        end
`else
                        idx_d   = '0;
                        state_d = ST_DONE;
`endif
                    end
                end
            end
            ST_DONE: begin
                if (bus.i_rx_done) ovr_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                tmo_d   = '0;
            end
        endcase
    end

    // State and control registers; reset abandons any frame in flight.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            tmo_q     <= '0;
            gap_q     <= 1'b0;
            tx_data_q <= '0;
            tx_en_q   <= 1'b0;
            err_q     <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef IMFILTER_CHECKSUM_EN
            sum_q     <= '0;
            chk_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            gap_q     <= gap_d;
            tx_data_q <= tx_data_d;
            tx_en_q   <= tx_en_d;
            err_q     <= err_d;
            ovr_q     <= ovr_d;
`ifdef IMFILTER_CHECKSUM_EN
            sum_q     <= sum_d;
            chk_q     <= chk_d;
`endif
        end
    end

    assign bus.o_op_req      = op_req;
    assign bus.o_op_data     = op_req ? buf_rdata : '0;
    assign bus.o_tx_data     = tx_data_q;
    assign bus.o_tx_enable   = tx_en_q;
    assign bus.o_busy        = (state_q != ST_IDLE);
    assign bus.o_frame_done  = (state_q == ST_DONE);
    assign bus.o_err_timeout = err_q;
    assign bus.o_overrun     = ovr_q;
endmodule
